// File: rtl/tally_reporter.sv
// tally_reporter: snapshots four candidate counts on a tally-mode report
// request, picks the winner with a one-candidate-per-cycle compare, and
// streams a 7-byte result frame over a valid/ready byte link.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for report_req with mode=1
//   CMP    | four cycles, one snapshot examined per cycle against max
//   FMT    | publish winner/tie, build status byte and checksum
//   SEND   | stream HEADER, snap1..4, status, checksum; done after last
module tally_reporter #(
  parameter logic [7:0] HEADER = 8'hA5,
  parameter int         CNT_W  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mode,
  input  logic             report_req,
  input  logic [CNT_W-1:0] cand1_vote,
  input  logic [CNT_W-1:0] cand2_vote,
  input  logic [CNT_W-1:0] cand3_vote,
  input  logic [CNT_W-1:0] cand4_vote,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [2:0]       winner_id,
  output logic             tie
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_FMT  = 2'd2,
    S_SEND = 2'd3
  } state_t;

  state_t                  state, state_n;
  logic [3:0][CNT_W-1:0]   snap, snap_n;
  logic [CNT_W-1:0]        max_cnt, max_cnt_n;
  logic [1:0]              idx, idx_n;
  logic [2:0]              win_acc, win_acc_n;
  logic                    tie_acc, tie_acc_n;
  logic [7:0]              byte5, byte5_n;
  logic [7:0]              chk, chk_n;
  logic [2:0]              byte_idx, byte_idx_n;
  logic [7:0]              out_data_n;
  logic                    out_valid_n;
  logic                    busy_n;
  logic                    done_n;
  logic [2:0]              winner_id_n;
  logic                    tie_n;

  // Scratch values used inside the next-state logic.
  logic [CNT_W-1:0]        cur;
  logic                    hit;
  logic [2:0]              win_pub;
  logic                    tie_pub;
  logic [7:0]              b5_pub;
  logic [2:0]              nxt_idx;
  logic [7:0]              nxt_byte;

  // State and datapath register; every output comes straight from here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      snap      <= '0;
      max_cnt   <= '0;
      idx       <= '0;
      win_acc   <= '0;
      tie_acc   <= 1'b0;
      byte5     <= '0;
      chk       <= '0;
      byte_idx  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      winner_id <= '0;
      tie       <= 1'b0;
    end else begin
      state     <= state_n;
      snap      <= snap_n;
      max_cnt   <= max_cnt_n;
      idx       <= idx_n;
      win_acc   <= win_acc_n;
      tie_acc   <= tie_acc_n;
      byte5     <= byte5_n;
      chk       <= chk_n;
      byte_idx  <= byte_idx_n;
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
      busy      <= busy_n;
      done      <= done_n;
      winner_id <= winner_id_n;
      tie       <= tie_n;
    end
  end

  // Next-state, compare, frame formatting and byte sequencing.
  always_comb begin
    state_n     = state;
    snap_n      = snap;
    max_cnt_n   = max_cnt;
    idx_n       = idx;
    win_acc_n   = win_acc;
    tie_acc_n   = tie_acc;
    byte5_n     = byte5;
    chk_n       = chk;
    byte_idx_n  = byte_idx;
    out_data_n  = out_data;
    out_valid_n = out_valid;
    done_n      = 1'b0;
    winner_id_n = winner_id;
    tie_n       = tie;

    cur      = snap[idx];
    hit      = (max_cnt != '0);
    win_pub  = hit ? win_acc : 3'd0;
    tie_pub  = hit & tie_acc;
    b5_pub   = {tie_pub, 4'b0000, win_pub};
    nxt_idx  = byte_idx + 3'd1;
    nxt_byte = HEADER;

    // Byte that follows the one currently being offered.
    case (nxt_idx)
      3'd1:    nxt_byte = snap[0];
      3'd2:    nxt_byte = snap[1];
      3'd3:    nxt_byte = snap[2];
      3'd4:    nxt_byte = snap[3];
      3'd5:    nxt_byte = byte5;
      3'd6:    nxt_byte = chk;
      default: nxt_byte = HEADER;
    endcase

    case (state)
      S_IDLE: begin
        if (report_req && mode) begin
          snap_n    = {cand4_vote, cand3_vote, cand2_vote, cand1_vote};
          max_cnt_n = '0;
          idx_n     = '0;
          win_acc_n = '0;
          tie_acc_n = 1'b0;
          state_n   = S_CMP;
        end
      end

      S_CMP: begin
        // Strict greater-than keeps the lowest index on equal counts.
        if (cur > max_cnt) begin
          max_cnt_n = cur;
          win_acc_n = {1'b0, idx} + 3'd1;
          tie_acc_n = 1'b0;
        end else if ((cur == max_cnt) && hit) begin
          tie_acc_n = 1'b1;
        end
        idx_n = idx + 2'd1;
        if (idx == 2'd3) begin
          state_n = S_FMT;
        end
      end

      S_FMT: begin
        winner_id_n = win_pub;
        tie_n       = tie_pub;
        byte5_n     = b5_pub;
        chk_n       = HEADER ^ snap[0] ^ snap[1] ^ snap[2] ^ snap[3] ^ b5_pub;
        byte_idx_n  = '0;
        out_data_n  = HEADER;
        out_valid_n = 1'b1;
        state_n     = S_SEND;
      end

      S_SEND: begin
        // Without a handshake everything holds, so a stalled byte stays put.
        if (out_valid && out_ready) begin
          if (byte_idx == 3'd6) begin
            out_valid_n = 1'b0;
            done_n      = 1'b1;
            state_n     = S_IDLE;
          end else begin
            byte_idx_n = nxt_idx;
            out_data_n = nxt_byte;
          end
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_tally_reporter.sv
// Bench for tally_reporter: directed frames plus randomized counts and
// out_ready backpressure, checked against a plain-arithmetic winner model.
module tb_tally_reporter;

  logic       clock = 1'b0;
  logic       reset;
  logic       mode;
  logic       report_req;
  logic [7:0] c1, c2, c3, c4;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic [2:0] winner_id;
  logic       tie;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_f [7];
  logic [2:0] exp_w;
  logic       exp_t;

  tally_reporter dut (
    .clock      (clock),
    .reset      (reset),
    .mode       (mode),
    .report_req (report_req),
    .cand1_vote (c1),
    .cand2_vote (c2),
    .cand3_vote (c3),
    .cand4_vote (c4),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .winner_id  (winner_id),
    .tie        (tie)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Winner = first candidate holding the maximum; tie if more than one holds
  // a non-zero maximum; all-zero counts report no winner.
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    logic [7:0] v [4];
    int mx;
    int n;
    int first;
    v = '{a, b, c, d};
    mx = 0; n = 0; first = 0;
    for (int i = 0; i < 4; i++) if (int'(v[i]) > mx) mx = int'(v[i]);
    for (int i = 0; i < 4; i++) begin
      if (int'(v[i]) == mx && mx != 0) begin
        n++;
        if (first == 0) first = i + 1;
      end
    end
    exp_w = 3'(first);
    exp_t = (n > 1);
    exp_f[0] = 8'hA5;
    for (int i = 0; i < 4; i++) exp_f[i+1] = v[i];
    exp_f[5] = {exp_t, 4'b0000, exp_w};
    exp_f[6] = exp_f[0] ^ exp_f[1] ^ exp_f[2] ^ exp_f[3] ^ exp_f[4] ^ exp_f[5];
  endtask

  task automatic do_frame(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d,
                          input bit rnd, input bit inject, input string tag);
    logic [7:0] got [$];
    logic [7:0] held;
    bit stall;
    bit seen_done;
    bit extra;
    int first_valid;
    int done_t;
    int t;
    model(a, b, c, d);
    stall = 0; seen_done = 0; extra = 0; held = '0;
    first_valid = -1; done_t = -1;
    @(negedge clock);
    mode = 1'b1; c1 = a; c2 = b; c3 = c; c4 = d;
    report_req = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    report_req = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    if (rnd) begin
      c1 = 8'($urandom); c2 = 8'($urandom); c3 = 8'($urandom); c4 = 8'($urandom);
      mode = 1'($urandom_range(0, 1));
    end
    t = 0;
    while (t < 400 && !seen_done) begin
      if (t > 0) @(negedge clock);
      if (done) begin
        seen_done = 1;
        done_t = t;
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      end
      if (out_valid && first_valid < 0) first_valid = t;
      if (stall) begin
        check({tag, "_valid_held"}, 32'(out_valid), 32'd1);
        check({tag, "_data_held"}, 32'(out_data), 32'(held));
      end
      if (inject && t == 7) report_req = 1'b1;
      if (inject && t == 8) report_req = 1'b0;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) got.push_back(out_data);
      stall = out_valid && !out_ready;
      held = out_data;
      t++;
    end
    report_req = 1'b0;
    out_ready = 1'b1;
    mode = 1'b1;
    check({tag, "_done_seen"}, 32'(seen_done), 32'd1);
    check({tag, "_nbytes"}, 32'(got.size()), 32'd7);
    for (int i = 0; i < 7; i++)
      check($sformatf("%s_byte%0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF,
            32'(exp_f[i]));
    check({tag, "_winner"}, 32'(winner_id), 32'(exp_w));
    check({tag, "_tie"}, 32'(tie), 32'(exp_t));
    if (!rnd) begin
      check({tag, "_lat_valid"}, 32'(first_valid), 32'd5);
      check({tag, "_lat_done"}, 32'(done_t), 32'd12);
    end
    @(negedge clock);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    if (inject) begin
      for (int i = 0; i < 20; i++) begin
        if (out_valid || busy) extra = 1;
        @(negedge clock);
      end
      check({tag, "_no_second_frame"}, 32'(extra), 32'd0);
    end
  endtask

  initial begin
    bit any;
    reset = 1'b1; mode = 1'b0; report_req = 1'b0; out_ready = 1'b1;
    c1 = '0; c2 = '0; c3 = '0; c4 = '0;
    repeat (3) @(negedge clock);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_winner", 32'(winner_id), 32'd0);
    check("rst_tie", 32'(tie), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    reset = 1'b0;

    do_frame(8'd3, 8'd7, 8'd2, 8'd5, 0, 0, "t1");
    do_frame(8'd4, 8'd9, 8'd9, 8'd1, 0, 0, "t2");
    do_frame(8'd0, 8'd0, 8'd0, 8'd0, 0, 0, "t3");
    do_frame(8'd3, 8'd7, 8'd2, 8'd5, 1, 0, "t4");

    // Request in voting mode must be ignored.
    @(negedge clock);
    mode = 1'b0; report_req = 1'b1; any = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (busy || out_valid) any = 1;
    end
    report_req = 1'b0; mode = 1'b1;
    check("t5_mode0_ignored", 32'(any), 32'd0);

    do_frame(8'd10, 8'd20, 8'd30, 8'd40, 0, 1, "t5b");

    // Reset after four bytes (index 0..3) have been accepted.
    @(negedge clock);
    c1 = 8'd3; c2 = 8'd7; c3 = 8'd2; c4 = 8'd5; mode = 1'b1;
    report_req = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    report_req = 1'b0;
    repeat (9) @(negedge clock);
    check("t6_mid_valid", 32'(out_valid), 32'd1);
    check("t6_mid_winner", 32'(winner_id), 32'd2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_winner", 32'(winner_id), 32'd0);
    check("t6_rst_tie", 32'(tie), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    do_frame(8'd6, 8'd1, 8'd6, 8'd2, 0, 0, "t6_fresh");

    for (int k = 0; k < 8; k++) begin
      logic [7:0] r [4];
      for (int j = 0; j < 4; j++)
        r[j] = (k < 4) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      do_frame(r[0], r[1], r[2], r[3], 1, 0, $sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
